st_packet_channel_arbiter: RTL and testbench

Packet-level round-robin arbiter that merges NUM_IN independent Avalon-ST byte-packet sources onto one channelized Avalon-ST stream, tagging each beat with the source index on `out_channel`. It sits upstream of the DDR3 control bytes-to-packets channel adapter. Packets are never interleaved: a grant is held from startofpacket through the accepted endofpacket beat. Output is fully registered.

---
 rtl/st_packet_channel_arbiter_pkg.sv | 23 ++
 rtl/st_packet_channel_arbiter_rr_priority_pick.sv | 35 +++
 rtl/st_packet_channel_arbiter.sv | 119 +++++++++++
 tb/tb_st_packet_channel_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/st_packet_channel_arbiter_pkg.sv
// Shared types and helpers for the packet channel arbiter.
// Holds the arbiter state encoding, the index-width function and default parameters.
package st_packet_channel_arbiter_pkg;

    localparam int NUM_IN_DEFAULT    = 4;
    localparam int DATA_W_DEFAULT    = 8;
    localparam int CHANNEL_W_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/st_packet_channel_arbiter_rr_priority_pick.sv
// Round-robin pick: first requesting index scanning last+1, last+2, ... modulo NUM_IN.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the winner is consumed.
module rr_priority_pick
    import st_packet_channel_arbiter_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEFAULT,
    parameter int IDX_W  = clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic              any,
    output logic [IDX_W-1:0]  winner
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        winner = '0;
        // k runs to NUM_IN so that `last` itself is the lowest-priority candidate
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = IDX_W'((int'(last) + k) % NUM_IN);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/st_packet_channel_arbiter.sv
// Merges NUM_IN byte-packet sources onto one channelized stream, one whole packet per grant.
// Latency: one arbitration cycle per packet, then 1 cycle from input accept to out_valid.
// Backpressure: only the granted source sees in_ready, high while the output register is free.
module st_packet_channel_arbiter
    import st_packet_channel_arbiter_pkg::*;
#(
    parameter int NUM_IN    = NUM_IN_DEFAULT,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int CHANNEL_W = CHANNEL_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_startofpacket,
    input  logic [NUM_IN-1:0]        in_endofpacket,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CHANNEL_W-1:0]     out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic                     err_no_sop
);

    localparam int IDX_W = clog2(NUM_IN);

    arb_state_t       state;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] last;
    logic             first_beat;

    logic             pick_any;
    logic [IDX_W-1:0] pick;

    logic             slot_free;
    logic             accept;
    logic [DATA_W-1:0] grant_data;
    logic             grant_valid;
    logic             grant_sop;
    logic             grant_eop;

    rr_priority_pick #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req    (in_valid),
        .last   (last),
        .any    (pick_any),
        .winner (pick)
    );

    // in_ready depends only on registered state and out_ready, never on in_valid
    assign slot_free = !out_valid || out_ready;

    always_comb begin
        in_ready = '0;
        if (state == BUSY && slot_free) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign grant_valid = in_valid[grant];
    assign grant_sop   = in_startofpacket[grant];
    assign grant_eop   = in_endofpacket[grant];
    assign grant_data  = in_data[int'(grant)*DATA_W +: DATA_W];
    assign accept      = grant_valid && in_ready[grant];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            grant             <= '0;
            last              <= IDX_W'(NUM_IN - 1);
            first_beat        <= 1'b0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_channel       <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            err_no_sop        <= 1'b0;
        end else begin
            if (accept) begin
                out_valid         <= 1'b1;
                out_data          <= grant_data;
                out_channel       <= CHANNEL_W'(grant);
                out_startofpacket <= grant_sop;
                out_endofpacket   <= grant_eop;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant      <= pick;
                        first_beat <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        first_beat <= 1'b0;
                        // a grant that opens without SOP is still forwarded, just flagged
                        if (first_beat && !grant_sop) begin
                            err_no_sop <= 1'b1;
                        end
                        if (grant_eop) begin
                            last  <= grant;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_st_packet_channel_arbiter.sv
// Bench for st_packet_channel_arbiter: directed scenarios plus randomized packet traffic
// checked against a packet-level round-robin model.
module tb_st_packet_channel_arbiter;

    localparam int NUM_IN    = 4;
    localparam int DATA_W    = 8;
    localparam int CHANNEL_W = 8;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    typedef struct packed {
        logic [7:0] ch;
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } obeat_t;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_ready;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_sop;
    logic [NUM_IN-1:0]        in_eop;
    logic                     out_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [CHANNEL_W-1:0]     out_channel;
    logic                     out_sop;
    logic                     out_eop;
    logic                     err_no_sop;

    int checks = 0;
    int errors = 0;

    beat_t  src_q[NUM_IN][$];
    obeat_t exp_q[$];
    bit     rdy_pat[$];
    bit     gaps     = 1'b0;
    bit     rand_rdy = 1'b0;
    bit     mon_en   = 1'b0;

    beat_t  m_src[NUM_IN][$];
    int     m_len[NUM_IN][$];
    int     m_last;

    st_packet_channel_arbiter #(
        .NUM_IN    (NUM_IN),
        .DATA_W    (DATA_W),
        .CHANNEL_W (CHANNEL_W)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_startofpacket  (in_sop),
        .in_endofpacket    (in_eop),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_channel       (out_channel),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .err_no_sop        (err_no_sop)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One source: presents its queued beats, honours in_ready, may idle mid-packet only.
    task automatic src_proc(input int s);
        bit    mid = 1'b0;
        beat_t b;
        while (src_q[s].size() > 0) begin
            b = src_q[s][0];
            if (mid && gaps && $urandom_range(0, 3) == 0) begin
                in_valid[s] = 1'b0;
            end else begin
                in_valid[s]                  = 1'b1;
                in_data[s*DATA_W +: DATA_W]  = b.d;
                in_sop[s]                    = b.sop;
                in_eop[s]                    = b.eop;
                if (in_ready[s]) begin
                    void'(src_q[s].pop_front());
                    mid = !b.eop;
                end
            end
            @(negedge clk);
        end
        in_valid[s] = 1'b0;
    endtask

    task automatic monitor();
        obeat_t      e;
        bit          stall = 1'b0;
        logic [18:0] prev  = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("in_ready_onehot", 32'($countones(in_ready) <= 1), 32'd1);
                if (out_valid && !out_ready)
                    chk("in_ready_stall", 32'(in_ready), 32'd0);
                if (stall)
                    chk("stall_hold", 32'({out_valid, out_sop, out_eop, out_channel, out_data}), 32'(prev));
                if (out_valid && out_ready) begin
                    chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("out_beat", 32'({out_channel, out_data, out_sop, out_eop}),
                            32'({e.ch, e.d, e.sop, e.eop}));
                    end
                end
                stall = out_valid && !out_ready;
                prev  = {out_valid, out_sop, out_eop, out_channel, out_data};
            end else begin
                stall = 1'b0;
            end
        end
    endtask

    task automatic rdy_drv();
        forever begin
            @(posedge clk);
            #1;
            if (rdy_pat.size() > 0) out_ready = rdy_pat.pop_front();
            else if (rand_rdy)      out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic add_pkt(input int s, input int len, input logic [7:0] base,
                           input logic [7:0] step, input bit sop_ok);
        for (int i = 0; i < len; i++)
            src_q[s].push_back('{d: base + 8'(i) * step, sop: (i == 0) && sop_ok, eop: (i == len - 1)});
    endtask

    task automatic expect_pkt(input int s, input int len, input logic [7:0] base,
                              input logic [7:0] step, input bit sop_ok);
        for (int i = 0; i < len; i++)
            exp_q.push_back('{ch: 8'(s), d: base + 8'(i) * step, sop: (i == 0) && sop_ok, eop: (i == len - 1)});
    endtask

    task automatic launch();
        for (int s = 0; s < NUM_IN; s++) begin
            automatic int ss = s;
            fork
                src_proc(ss);
            join_none
        end
    endtask

    // Waits until every expected beat has appeared; n = negedges from launch to last beat.
    task automatic drain(input string tag, input int bound, output int n);
        n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_dut();
        reset_n  = 1'b0;
        in_valid = '0;
        in_sop   = '0;
        in_eop   = '0;
        repeat (2) @(negedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int    n;
        int    len;
        int    np;
        int    s;
        bit    found;
        beat_t b;

        reset_n   = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_sop    = '0;
        in_eop    = '0;
        out_ready = 1'b1;
        fork
            monitor();
            rdy_drv();
        join_none

        // reset values
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_channel", 32'(out_channel), 32'd0);
        chk("rst_out_sop", 32'(out_sop), 32'd0);
        chk("rst_out_eop", 32'(out_eop), 32'd0);
        chk("rst_err", 32'(err_no_sop), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);

        // single 3-beat packet from source 0 at full rate
        mon_en = 1'b1;
        add_pkt(0, 3, 8'h11, 8'h11, 1'b1);
        expect_pkt(0, 3, 8'h11, 8'h11, 1'b1);
        launch();
        #1 chk("t1_idle_in_ready", 32'(in_ready), 32'd0);
        drain("t1", 50, n);
        chk("t1_cycles", 32'(n), 32'd4);

        // three simultaneous 2-beat packets: order 0,1,2 with one bubble each
        reset_dut();
        add_pkt(0, 2, 8'hA0, 8'h01, 1'b1);
        add_pkt(1, 2, 8'hB0, 8'h01, 1'b1);
        add_pkt(2, 2, 8'hC0, 8'h01, 1'b1);
        expect_pkt(0, 2, 8'hA0, 8'h01, 1'b1);
        expect_pkt(1, 2, 8'hB0, 8'h01, 1'b1);
        expect_pkt(2, 2, 8'hC0, 8'h01, 1'b1);
        launch();
        drain("t2", 80, n);
        chk("t2_cycles", 32'(n), 32'd9);

        // source 1 with out_ready toggling
        add_pkt(1, 4, 8'h40, 8'h01, 1'b1);
        expect_pkt(1, 4, 8'h40, 8'h01, 1'b1);
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        launch();
        drain("t3", 80, n);
        rdy_pat.delete();
        out_ready = 1'b1;

        // rotation from last: 3 done -> {0,3} gives 0; 0 done -> {0,3} gives 3
        reset_dut();
        add_pkt(3, 2, 8'h30, 8'h01, 1'b1);
        expect_pkt(3, 2, 8'h30, 8'h01, 1'b1);
        launch();
        drain("t4a", 50, n);
        add_pkt(0, 1, 8'h01, 8'h01, 1'b1);
        add_pkt(3, 1, 8'h03, 8'h01, 1'b1);
        expect_pkt(0, 1, 8'h01, 8'h01, 1'b1);
        expect_pkt(3, 1, 8'h03, 8'h01, 1'b1);
        launch();
        drain("t4b", 50, n);
        add_pkt(0, 1, 8'h0A, 8'h01, 1'b1);
        expect_pkt(0, 1, 8'h0A, 8'h01, 1'b1);
        launch();
        drain("t4c", 50, n);
        add_pkt(0, 1, 8'h0B, 8'h01, 1'b1);
        add_pkt(3, 1, 8'h3B, 8'h01, 1'b1);
        expect_pkt(3, 1, 8'h3B, 8'h01, 1'b1);
        expect_pkt(0, 1, 8'h0B, 8'h01, 1'b1);
        launch();
        drain("t4d", 50, n);

        // missing SOP on source 2: forwarded and flagged stickily until reset
        chk("t5_err_before", 32'(err_no_sop), 32'd0);
        add_pkt(2, 2, 8'h50, 8'h01, 1'b0);
        expect_pkt(2, 2, 8'h50, 8'h01, 1'b0);
        launch();
        drain("t5a", 50, n);
        chk("t5_err_set", 32'(err_no_sop), 32'd1);
        add_pkt(2, 2, 8'h58, 8'h01, 1'b1);
        expect_pkt(2, 2, 8'h58, 8'h01, 1'b1);
        launch();
        drain("t5b", 50, n);
        chk("t5_err_sticky", 32'(err_no_sop), 32'd1);
        reset_dut();
        chk("t5_err_cleared", 32'(err_no_sop), 32'd0);

        // reset during beat 2 of a 4-beat packet from source 1, with last = 0 beforehand
        add_pkt(0, 1, 8'h70, 8'h01, 1'b1);
        expect_pkt(0, 1, 8'h70, 8'h01, 1'b1);
        launch();
        drain("t6a", 50, n);
        mon_en = 1'b0;
        add_pkt(1, 4, 8'h60, 8'h01, 1'b1);
        launch();
        repeat (3) @(negedge clk);
        #1;
        chk("t6_beat2_visible", 32'({out_valid, out_data}), 32'({1'b1, 8'h61}));
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
        src_q[1].delete();
        repeat (2) @(negedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        add_pkt(0, 2, 8'h80, 8'h01, 1'b1);
        add_pkt(1, 2, 8'h90, 8'h01, 1'b1);
        expect_pkt(0, 2, 8'h80, 8'h01, 1'b1);
        expect_pkt(1, 2, 8'h90, 8'h01, 1'b1);
        launch();
        drain("t6b", 50, n);

        // randomized traffic against a packet-level rotation model
        reset_dut();
        m_last   = NUM_IN - 1;
        gaps     = 1'b1;
        rand_rdy = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int src = 0; src < NUM_IN; src++) begin
                np = $urandom_range(0, 4);
                for (int p = 0; p < np; p++) begin
                    len = $urandom_range(1, 5);
                    m_len[src].push_back(len);
                    for (int i = 0; i < len; i++) begin
                        b = '{d: 8'($urandom), sop: (i == 0), eop: (i == len - 1)};
                        src_q[src].push_back(b);
                        m_src[src].push_back(b);
                    end
                end
            end
            do begin
                found = 1'b0;
                for (int k = 1; k <= NUM_IN; k++) begin
                    s = (m_last + k) % NUM_IN;
                    if (!found && m_len[s].size() > 0) begin
                        found = 1'b1;
                        len   = m_len[s].pop_front();
                        for (int i = 0; i < len; i++) begin
                            b = m_src[s].pop_front();
                            exp_q.push_back('{ch: 8'(s), d: b.d, sop: b.sop, eop: b.eop});
                        end
                        m_last = s;
                    end
                end
            end while (found);
            launch();
            drain("rand", 4000, n);
        end
        gaps      = 1'b0;
        rand_rdy  = 1'b0;
        out_ready = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
